// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared limits and 12-hour display mapping for the hms counter
package rtc_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HRS_MAX = 23;

    // Internal 24-hour value to 12-hour display value: 0 -> 12, 13..23 -> h-12.
    function automatic logic [31:0] to_12h(input logic [31:0] hours);
        if (hours == 32'd0) begin
            return 32'd12;
        end else if (hours > 32'd12) begin
            return hours - 32'd12;
        end else begin
            return hours;
        end
    endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// rtl/rtc_mod_counter.sv - modulo (MAX_VAL+1) field counter with load and wrap
//   clk, reset (async active-low), en (advance), load/load_val (overrides en),
//   count (current value), wrap (combinational: en while count == MAX_VAL)
module rtc_mod_counter #(
    parameter int WIDTH   = 6,
    parameter int MAX_VAL = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == WIDTH'(MAX_VAL));
    assign wrap   = en && at_max;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rtc_hms_counter.sv
// rtl/rtc_hms_counter.sv - hours/minutes/seconds counter with prescaler, load and 12/24h display
//   clk, reset (async active-low), run, mode_12h
//   load, load_sec/min/hrs -> load_err
//   count_sec/min/hrs, pm, sec_stb/min_stb/hrs_stb/day_stb
//   alarm_en, alarm_hrs, alarm_min -> alarm_hit (logic present only with RTC_HMS_ALARM_EN)
module rtc_hms_counter
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int CNT_W         = 6,
    parameter int PRE_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mode_12h,
    input  logic             load,
    input  logic [CNT_W-1:0] load_sec,
    input  logic [CNT_W-1:0] load_min,
    input  logic [CNT_W-1:0] load_hrs,
    output logic             load_err,
    output logic [CNT_W-1:0] count_sec,
    output logic [CNT_W-1:0] count_min,
    output logic [CNT_W-1:0] count_hrs,
    output logic             pm,
    output logic             sec_stb,
    output logic             min_stb,
    output logic             hrs_stb,
    output logic             day_stb,
    input  logic             alarm_en,
    input  logic [CNT_W-1:0] alarm_hrs,
    input  logic [CNT_W-1:0] alarm_min,
    output logic             alarm_hit
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic             load_ok, load_bad;
    logic             sec_en;
    logic             sec_wrap, min_wrap, hrs_wrap;
    logic [CNT_W-1:0] sec_val, min_val, hrs_val;
    logic             sec_stb_q, min_stb_q, hrs_stb_q, day_stb_q, load_err_q;

    assign tick = run && (pre_q == PRE_W'(TICKS_PER_SEC - 1));

    assign load_ok  = load && (load_sec <= CNT_W'(SEC_MAX))
                           && (load_min <= CNT_W'(MIN_MAX))
                           && (load_hrs <= CNT_W'(HRS_MAX));
    assign load_bad = load && !load_ok;

    // A valid load swallows a coincident tick so the new time starts a full second.
    assign sec_en = tick && !load_ok;

    always_comb begin
        pre_d = pre_q;
        if (load_ok) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q      <= '0;
            sec_stb_q  <= 1'b0;
            min_stb_q  <= 1'b0;
            hrs_stb_q  <= 1'b0;
            day_stb_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_stb_q  <= sec_en;
            min_stb_q  <= sec_wrap;
            hrs_stb_q  <= min_wrap;
            day_stb_q  <= hrs_wrap;
            load_err_q <= load_bad;
        end
    end

    rtc_mod_counter #(.WIDTH(CNT_W), .MAX_VAL(SEC_MAX)) u_sec (
        .clk(clk), .reset(reset), .en(sec_en), .load(load_ok),
        .load_val(load_sec), .count(sec_val), .wrap(sec_wrap)
    );

    rtc_mod_counter #(.WIDTH(CNT_W), .MAX_VAL(MIN_MAX)) u_min (
        .clk(clk), .reset(reset), .en(sec_wrap), .load(load_ok),
        .load_val(load_min), .count(min_val), .wrap(min_wrap)
    );

    rtc_mod_counter #(.WIDTH(CNT_W), .MAX_VAL(HRS_MAX)) u_hrs (
        .clk(clk), .reset(reset), .en(min_wrap), .load(load_ok),
        .load_val(load_hrs), .count(hrs_val), .wrap(hrs_wrap)
    );

    assign count_sec = sec_val;
    assign count_min = min_val;
    assign count_hrs = mode_12h ? CNT_W'(to_12h(32'(hrs_val))) : hrs_val;
    assign pm        = (hrs_val >= CNT_W'(12));
    assign sec_stb   = sec_stb_q;
    assign min_stb   = min_stb_q;
    assign hrs_stb   = hrs_stb_q;
    assign day_stb   = day_stb_q;
    assign load_err  = load_err_q;

`ifdef RTC_HMS_ALARM_EN
    logic [CNT_W-1:0] nxt_min, nxt_hrs;
    logic             alarm_valid;
    logic             alarm_hit_q;

    // Time the counter is about to show; only a seconds wrap can land on hh:mm:00.
    always_comb begin
        nxt_min = min_wrap ? '0 : min_val + CNT_W'(1);
        nxt_hrs = hrs_val;
        if (min_wrap) begin
            nxt_hrs = hrs_wrap ? '0 : hrs_val + CNT_W'(1);
        end
    end

    assign alarm_valid = (alarm_hrs <= CNT_W'(HRS_MAX)) && (alarm_min <= CNT_W'(MIN_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_hit_q <= alarm_en && alarm_valid && sec_wrap
                           && (nxt_min == alarm_min) && (nxt_hrs == alarm_hrs);
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_en, alarm_hrs, alarm_min};
    assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_hms_counter.sv
// tb/tb_rtc_hms_counter.sv - directed self-checking bench for rtc_hms_counter
module tb_rtc_hms_counter;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic             mode_12h;
    logic             load;
    logic [CNT_W-1:0] load_sec, load_min, load_hrs;
    logic             load_err;
    logic [CNT_W-1:0] count_sec, count_min, count_hrs;
    logic             pm;
    logic             sec_stb, min_stb, hrs_stb, day_stb;
    logic             alarm_en;
    logic [CNT_W-1:0] alarm_hrs, alarm_min;
    logic             alarm_hit;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rtc_hms_counter #(.TICKS_PER_SEC(4), .CNT_W(CNT_W), .PRE_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
        .load(load), .load_sec(load_sec), .load_min(load_min), .load_hrs(load_hrs),
        .load_err(load_err), .count_sec(count_sec), .count_min(count_min),
        .count_hrs(count_hrs), .pm(pm), .sec_stb(sec_stb), .min_stb(min_stb),
        .hrs_stb(hrs_stb), .day_stb(day_stb), .alarm_en(alarm_en),
        .alarm_hrs(alarm_hrs), .alarm_min(alarm_min), .alarm_hit(alarm_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, " hrs"}, 32'(count_hrs), 32'(h));
        check({tag, " min"}, 32'(count_min), 32'(m));
        check({tag, " sec"}, 32'(count_sec), 32'(s));
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load     = 1'b1;
        load_hrs = CNT_W'(h);
        load_min = CNT_W'(m);
        load_sec = CNT_W'(s);
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; mode_12h = 1'b0; load = 1'b0;
        load_sec = '0; load_min = '0; load_hrs = '0;
        alarm_en = 1'b0; alarm_hrs = '0; alarm_min = '0;

        // Reset state
        step(3);
        check_time("reset", 0, 0, 0);
        check("reset sec_stb", 32'(sec_stb), 0);
        check("reset day_stb", 32'(day_stb), 0);
        check("reset load_err", 32'(load_err), 0);
        check("reset pm", 32'(pm), 0);
        mode_12h = 1'b1; #1;
        check("reset hrs 12h", 32'(count_hrs), 12);
        mode_12h = 1'b0; #1;

        // Free run: a second every 4 edges
        reset = 1'b1; run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("run sec e%0d", i), 32'(count_sec), 32'(i / 4));
            check($sformatf("run stb e%0d", i), 32'(sec_stb), 32'((i % 4) == 0));
        end

        // Day rollover
        do_load(23, 59, 58);
        check_time("load 23:59:58", 23, 59, 58);
        check("load no sec_stb", 32'(sec_stb), 0);
        step(4);
        check_time("23:59:59", 23, 59, 59);
        check("59 sec_stb", 32'(sec_stb), 1);
        check("59 min_stb", 32'(min_stb), 0);
        step(4);
        check_time("rollover", 0, 0, 0);
        check("roll sec_stb", 32'(sec_stb), 1);
        check("roll min_stb", 32'(min_stb), 1);
        check("roll hrs_stb", 32'(hrs_stb), 1);
        check("roll day_stb", 32'(day_stb), 1);
        step(1);
        check("roll day_stb drop", 32'(day_stb), 0);

        // 12-hour display
        mode_12h = 1'b1;
        do_load(13, 5, 0);
        check("13h disp", 32'(count_hrs), 1);
        check("13h pm", 32'(pm), 1);
        do_load(0, 0, 0);
        check("0h disp", 32'(count_hrs), 12);
        check("0h pm", 32'(pm), 0);
        mode_12h = 1'b0; #1;
        check_time("24h mode", 0, 0, 0);

        // Rejected loads (prescaler 0 -> 1 -> 2 -> 3)
        do_load(24, 30, 30);
        check_time("bad hrs", 0, 0, 0);
        check("bad hrs load_err", 32'(load_err), 1);
        step(1);
        check("load_err one cycle", 32'(load_err), 0);
        do_load(10, 20, 60);
        check_time("bad sec", 0, 0, 0);
        check("bad sec load_err", 32'(load_err), 1);

        // Load on the tick cycle: load wins, next second 4 edges later
        do_load(10, 20, 30);
        check_time("load on tick", 10, 20, 30);
        check("load on tick stb", 32'(sec_stb), 0);
        check("good load no err", 32'(load_err), 0);
        step(3);
        check("tick discarded", 32'(count_sec), 30);
        step(1);
        check("next sec", 32'(count_sec), 31);
        check("next sec stb", 32'(sec_stb), 1);

        // Pause mid-second: prescaler holds its phase
        step(2);
        run = 1'b0;
        step(10);
        check("paused sec", 32'(count_sec), 31);
        check("paused stb", 32'(sec_stb), 0);
        run = 1'b1;
        step(1);
        check("resume sec", 32'(count_sec), 31);
        step(1);
        check("resume step", 32'(count_sec), 32);
        check("resume stb", 32'(sec_stb), 1);

        // Alarm at 07:30
        alarm_hrs = CNT_W'(7); alarm_min = CNT_W'(30); alarm_en = 1'b1;
`ifdef RTC_HMS_ALARM_EN
        do_load(7, 29, 58);
        step(4);
        check("alarm early", 32'(alarm_hit), 0);
        step(4);
        check_time("alarm time", 7, 30, 0);
        check("alarm hit", 32'(alarm_hit), 1);
        step(1);
        check("alarm drop", 32'(alarm_hit), 0);
        alarm_en = 1'b0;
        do_load(7, 29, 59);
        step(4);
        check("alarm disabled", 32'(alarm_hit), 0);
        alarm_en = 1'b1;
        do_load(7, 30, 0);
        check("alarm on load", 32'(alarm_hit), 0);
`else
        do_load(7, 29, 59);
        step(4);
        check_time("alarm time", 7, 30, 0);
        check("alarm tied off", 32'(alarm_hit), 0);
`endif

        // Reset mid-count beats a pending load
        load = 1'b1; load_hrs = CNT_W'(5); load_min = CNT_W'(6); load_sec = CNT_W'(7);
        reset = 1'b0; #2;
        check_time("async reset", 0, 0, 0);
        step(1);
        check_time("reset over load", 0, 0, 0);
        load = 1'b0; reset = 1'b1;
        step(1);
        check_time("after reset", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_hms_counter.md
Name: rtc_hms_counter

Overview:
- Parametrised hours/minutes/seconds real-time counter.
- Adds a built-in seconds prescaler, run/pause control, validated time load, a 12/24-hour display mode and carry strobes.
- Sits between the system clock and the display/alarm logic.
- Internal time is always kept in 24-hour form.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per second (must be >= 2).
- CNT_W, 6, width of each time field (must be >= 6).
- PRE_W, 16, prescaler counter width (must hold TICKS_PER_SEC-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = prescaler advances; 0 = time frozen, prescaler holds.
- mode_12h  in  1  display mode: 1 = 12-hour, 0 = 24-hour.
- load  in  1  single-cycle request to load a new time.
- load_sec  in  CNT_W  seconds value to load, 0..59.
- load_min  in  CNT_W  minutes value to load, 0..59.
- load_hrs  in  CNT_W  hours value to load, 24-hour form, 0..23.
- load_err  out  1  one-cycle pulse: load rejected.
- count_sec  out  CNT_W  seconds.
- count_min  out  CNT_W  minutes.
- count_hrs  out  CNT_W  hours, display form per mode_12h.
- pm  out  1  1 when internal hours >= 12 (valid in both modes).
- sec_stb  out  1  one-cycle strobe when seconds advance.
- min_stb  out  1  one-cycle strobe when minutes advance.
- hrs_stb  out  1  one-cycle strobe when hours advance.
- day_stb  out  1  one-cycle strobe on 23:59:59 -> 00:00:00.
- alarm_en, alarm_hrs, alarm_min  in  1/CNT_W/CNT_W  alarm controls (see Optional Feature).
- alarm_hit  out  1  alarm pulse.

Behaviour:
- Reset (reset=0, asynchronous): prescaler, sec, min and internal hours = 0; all strobes = 0; load_err = 0.
- count_hrs is derived combinationally from internal hours and mode_12h. It therefore reads 0 after reset in 24-hour mode and 12 in 12-hour mode.
- Prescaler: when run=1, counts 0..TICKS_PER_SEC-1 and wraps to 0. The internal tick is high in the cycle where the prescaler equals TICKS_PER_SEC-1.
- When run=0, the prescaler holds and no tick occurs.
- On a tick edge, sec increments. At 59 it wraps to 0 and carries into min.
- Min wraps at 59 and carries into hours.
- Hours wrap at 23 to 0.
- All fields update on the same edge; there is no ripple latency.
- Strobes are registered and high for exactly the one cycle in which the new value is first visible. For example, min_stb is coincident with count_min changing. day_stb is coincident with 00:00:00.
- Load: load=1 with sec<=59, min<=59 and hrs<=23 replaces all three fields on the next edge and clears the prescaler to 0.
  - Load has priority over a same-cycle tick; that tick is discarded.
  - No strobes fire on a load.
- If any load field is out of range, time is unchanged and load_err pulses on the next cycle.
- 12-hour display mapping: hours 0 -> 12; 1..12 -> unchanged; 13..23 -> h-12. pm = (hours >= 12).
- mode_12h may change at any time. It affects only display, never stored time.
- Reset mid-count wins over everything, including a pending load.

Optional Feature:
- Macro: RTC_HMS_ALARM_EN.
- Defined: the alarm logic is compiled in.
  - alarm_hit pulses one cycle, coincident with the tick edge that makes the time alarm_hrs:alarm_min:00, provided alarm_en=1.
  - A load to the matching time does not trigger it.
  - Out-of-range alarm values never match.
- Undefined: the alarm ports remain present, alarm inputs are ignored, and alarm_hit is tied to 0.

Decomposition:
- Shared package rtc_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HRS_MAX=23;
  - function to_12h(hours) returning the display value.
- Sub-module rtc_mod_counter (parameters WIDTH and MAX_VAL; ports en, load, load_val; outputs count and wrap) is used once per field.
- The prescaler and strobe registers stay in the top level.

Test Plan (TICKS_PER_SEC=4):
- Reset released, run=1, 12 cycles -> count_sec steps 0,1,2,3 every 4 cycles; sec_stb pulses coincide with each change.
- Load 23:59:58, run 8 cycles -> 23:59:59, then 00:00:00. day_stb, hrs_stb, min_stb and sec_stb all pulse on the wrap cycle.
- Load 13:05:00 with mode_12h=1 -> count_hrs=1, pm=1. Load 00:00:00 -> count_hrs=12, pm=0. Toggle mode_12h to 0 -> count_hrs=0 with no change to stored time.
- Load hrs=24 (or sec=60) -> time unchanged and load_err pulses once. Assert load on the tick cycle -> loaded value wins and the next increment occurs 4 cycles later.
- Drop run for 10 cycles mid-second, then restore -> no change while paused; the count resumes from the held prescaler phase.
- With RTC_HMS_ALARM_EN and alarm 07:30: count from 07:29:58 -> alarm_hit pulses on 07:30:00. With alarm_en=0, no pulse occurs. A direct load of 07:30:00 causes no pulse.
